// File: rtl/serdes_comma_pkg.sv
// Shared definitions for the RX comma detector / word aligner.
//   K28_5_RDN, K28_5_RDP : both running-disparity encodings of the K28.5 comma
//   COMMA_WIDTH          : width of one 8b/10b code group
//   align_state_e        : word-alignment FSM states
//   is_comma()           : true when a 10-bit code group is either K28.5 form
package serdes_comma_pkg;

  localparam int COMMA_WIDTH = 10;

  localparam logic [COMMA_WIDTH-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [COMMA_WIDTH-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    UNALIGNED,
    ACQUIRE,
    LOCKED
  } align_state_e;

  function automatic logic is_comma(input logic [COMMA_WIDTH-1:0] i_code);
    return (i_code == K28_5_RDN) || (i_code == K28_5_RDP);
  endfunction

endpackage

// File: rtl/comma_offset_finder.sv
// Purely combinational K28.5 scanner over a two-word sliding window.
//   i_window    : {previous word, current word}; MSB is the earliest bit
//   o_match     : at least one offset holds a comma
//   o_offset    : lowest offset holding a comma (0 when none)
//   o_match_vec : one bit per offset; bit k set when the candidate at k matches
module comma_offset_finder
  import serdes_comma_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2*W-1:0]         i_window,
  output logic                   o_match,
  output logic [$clog2(W)-1:0]   o_offset,
  output logic [W-1:0]           o_match_vec
);

  localparam int OW = $clog2(W);

  // Candidate k starts k bits after the MSB of the previous word.
  for (genvar k = 0; k < W; k++) begin : g_cand
    assign o_match_vec[k] = is_comma(i_window[2*W-1-k -: COMMA_WIDTH]);
  end

  assign o_match = |o_match_vec;

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    o_offset = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (o_match_vec[k]) o_offset = OW'(k);
    end
  end

endmodule

// File: rtl/comma_aligner.sv
// K28.5 comma detector and word aligner between deserializer and 8b/10b decoder.
//   CLK          : RX parallel-domain clock
//   Rst_n        : synchronous active-low reset
//   Data_in      : deserialized word, MSB earliest received
//   Data_out     : realigned word (registered)
//   RxValid      : high while locked (registered)
//   Comma_pulse  : one cycle per comma found at the selected offset (registered)
//   Align_offset : currently selected bit offset (registered)
module comma_aligner
  import serdes_comma_pkg::*;
#(
  parameter int PARALLEL_DATA_WIDTH = 10,
  parameter int LOCK_COUNT          = 3,
  parameter int LOSS_COUNT          = 4
) (
  input  logic                                   CLK,
  input  logic                                   Rst_n,
  input  logic [PARALLEL_DATA_WIDTH-1:0]         Data_in,
  output logic [PARALLEL_DATA_WIDTH-1:0]         Data_out,
  output logic                                   RxValid,
  output logic                                   Comma_pulse,
  output logic [$clog2(PARALLEL_DATA_WIDTH)-1:0] Align_offset
);

  localparam int W       = PARALLEL_DATA_WIDTH;
  localparam int OW      = $clog2(W);
  localparam int WINW    = $clog2(2 * W);
  localparam int CNT_TOP = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] LOCK_THR = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] LOSS_THR = CW'(LOSS_COUNT);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_TOP);

  logic [W-1:0]    r_prev_word;
  align_state_e    r_state;
  logic [OW-1:0]   r_offset;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_miss;
  logic [W-1:0]    r_data_out;
  logic            r_rx_valid;
  logic            r_comma_pulse;

  logic [2*W-1:0]  w_window;
  logic            w_any_match;
  logic [OW-1:0]   w_low_offset;
  logic [W-1:0]    w_match_vec;
  logic            w_sel_match;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_miss_inc;
  align_state_e    w_next_state;
  logic [OW-1:0]   w_next_offset;
  logic [CW-1:0]   w_next_cnt;
  logic [CW-1:0]   w_next_miss;
  logic [WINW-1:0] w_out_base;
  logic [W-1:0]    w_aligned;

  assign w_window = {r_prev_word, Data_in};

  comma_offset_finder #(.W(W)) u_finder (
    .i_window    (w_window),
    .o_match     (w_any_match),
    .o_offset    (w_low_offset),
    .o_match_vec (w_match_vec)
  );

  // Sel_match looks at the offset held before this cycle's update.
  assign w_sel_match = w_match_vec[r_offset];

  // Saturating increments: counters hold at their top value instead of wrapping.
  assign w_cnt_inc  = (r_cnt  == CNT_SAT) ? r_cnt  : r_cnt  + CW'(1);
  assign w_miss_inc = (r_miss == CNT_SAT) ? r_miss : r_miss + CW'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left one
    // unassigned would infer a latch.
    w_next_state  = r_state;
    w_next_offset = r_offset;
    w_next_cnt    = r_cnt;
    w_next_miss   = r_miss;
    unique case (r_state)
      UNALIGNED: begin
        if (w_any_match) begin
          w_next_offset = w_low_offset;
          w_next_cnt    = CW'(1);
          w_next_miss   = '0;
          w_next_state  = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (w_sel_match) begin
          w_next_cnt = w_cnt_inc;
          if (w_cnt_inc >= LOCK_THR) begin
            w_next_state = LOCKED;
            w_next_miss  = '0;
          end
        end else if (w_any_match) begin
          // Comma moved: restart the count at the new boundary.
          w_next_offset = w_low_offset;
          w_next_cnt    = CW'(1);
        end
      end
      LOCKED: begin
        // Offset frozen; the locked offset's comma outranks any foreign one.
        if (w_sel_match) begin
          w_next_miss = '0;
        end else if (w_any_match) begin
          w_next_miss = w_miss_inc;
          if (w_miss_inc >= LOSS_THR) begin
            w_next_state = UNALIGNED;
            w_next_cnt   = '0;
            w_next_miss  = '0;
          end
        end
      end
      default: w_next_state = UNALIGNED;
    endcase
  end

  // Output word is taken at the offset in effect after this cycle's update.
  assign w_out_base = WINW'(2 * W - 1) - WINW'(w_next_offset);
  assign w_aligned  = w_window[w_out_base -: W];

  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge here, and every register,
    // including the data path, is cleared so no stale word leaks out.
    if (!Rst_n) begin
      r_prev_word   <= '0;
      r_state       <= UNALIGNED;
      r_offset      <= '0;
      r_cnt         <= '0;
      r_miss        <= '0;
      r_data_out    <= '0;
      r_rx_valid    <= 1'b0;
      r_comma_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state, independent of statement order.
      r_prev_word   <= Data_in;
      r_state       <= w_next_state;
      r_offset      <= w_next_offset;
      r_cnt         <= w_next_cnt;
      r_miss        <= w_next_miss;
      r_data_out    <= w_aligned;
      r_rx_valid    <= (w_next_state == LOCKED);
      r_comma_pulse <= w_match_vec[w_next_offset] && (w_next_state != UNALIGNED);
    end
  end

  assign Data_out     = r_data_out;
  assign RxValid      = r_rx_valid;
  assign Comma_pulse  = r_comma_pulse;
  assign Align_offset = r_offset;

endmodule

// File: tb/tb_comma_aligner.sv
// Self-checking bench for comma_aligner (W=10, LOCK_COUNT=3, LOSS_COUNT=4).
// Stimulus is built as a serial bit stream in a queue and chopped into words;
// a stream-level model tracks alignment and predicts every registered output.
module tb_comma_aligner;

  localparam logic [9:0] RDN = 10'b0011111010;
  localparam logic [9:0] RDP = 10'b1100000101;
  localparam int LOCK_N = 3;
  localparam int LOSS_N = 4;
  localparam int M_HUNT = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic       CLK;
  logic       Rst_n;
  logic [9:0] Data_in;
  logic [9:0] Data_out;
  logic       RxValid;
  logic       Comma_pulse;
  logic [3:0] Align_offset;

  comma_aligner #(
    .PARALLEL_DATA_WIDTH(10),
    .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N)
  ) dut (
    .CLK          (CLK),
    .Rst_n        (Rst_n),
    .Data_in      (Data_in),
    .Data_out     (Data_out),
    .RxValid      (RxValid),
    .Comma_pulse  (Comma_pulse),
    .Align_offset (Align_offset)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (stream level).
  logic [9:0] m_prev;
  int         m_mode, m_off, m_cnt, m_miss;
  logic [9:0] e_data;
  logic       e_valid, e_pulse;
  int         e_off;

  task automatic model_edge(input bit rst, input logic [9:0] din);
    logic [19:0] win;
    logic [19:0] sh;
    logic [9:0]  hit;
    int          first;
    if (rst) begin
      m_prev = '0; m_mode = M_HUNT; m_off = 0; m_cnt = 0; m_miss = 0;
      e_data = '0; e_valid = 1'b0; e_pulse = 1'b0; e_off = 0;
      return;
    end
    win   = {m_prev, din};
    first = -1;
    for (int k = 0; k < 10; k++) begin
      sh     = win >> (10 - k);
      hit[k] = (sh[9:0] == RDN) || (sh[9:0] == RDP);
      if (first < 0 && hit[k]) first = k;
    end
    case (m_mode)
      M_HUNT: if (first >= 0) begin
        m_off = first; m_cnt = 1; m_miss = 0;
        m_mode = (LOCK_N == 1) ? M_LOCK : M_ACQ;
      end
      M_ACQ: begin
        if (hit[m_off]) begin
          m_cnt++;
          if (m_cnt == LOCK_N) begin m_mode = M_LOCK; m_miss = 0; end
        end else if (first >= 0) begin
          m_off = first; m_cnt = 1;
        end
      end
      default: begin
        if (hit[m_off]) m_miss = 0;
        else if (first >= 0) begin
          m_miss++;
          if (m_miss == LOSS_N) begin m_mode = M_HUNT; m_cnt = 0; m_miss = 0; end
        end
      end
    endcase
    sh      = win << m_off;
    e_data  = sh[19:10];
    e_off   = m_off;
    e_pulse = hit[m_off] && (m_mode != M_HUNT);
    e_valid = (m_mode == M_LOCK);
    m_prev  = din;
  endtask

  // Observation side channels used by scenario-level checks.
  int         pulse_cnt;
  logic [9:0] last_pulse_data;
  bit         saw_lock_at2;

  task automatic compare_outputs();
    check("data_out", 32'(Data_out), 32'(e_data));
    check("rx_valid", 32'(RxValid), 32'(e_valid));
    check("comma_pulse", 32'(Comma_pulse), 32'(e_pulse));
    check("align_offset", 32'(Align_offset), 32'(e_off));
  endtask

  task automatic step(input logic [9:0] w);
    @(negedge CLK);
    Rst_n   = 1'b1;
    Data_in = w;
    model_edge(1'b0, w);
    @(posedge CLK);
    #1;
    compare_outputs();
    if (Comma_pulse) begin
      pulse_cnt++;
      last_pulse_data = Data_out;
    end
    if (RxValid && Align_offset == 4'd2) saw_lock_at2 = 1'b1;
  endtask

  // Serial stream builder.
  bit   bq[$];
  logic lb;

  task automatic do_reset();
    @(negedge CLK);
    Rst_n   = 1'b0;
    Data_in = 10'($urandom);
    model_edge(1'b1, '0);
    @(posedge CLK);
    #1;
    compare_outputs();
    bq.delete();
    lb = 1'b0;
    pulse_cnt = 0;
    saw_lock_at2 = 1'b0;
    last_pulse_data = '0;
  endtask

  task automatic push_bits(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) bq.push_back(v[i]);
    lb = v[0];
  endtask

  task automatic push_filler(input int n);
    repeat (n) begin
      lb = ~lb;
      bq.push_back(lb);
    end
  endtask

  task automatic flush();
    logic [9:0] w;
    while (bq.size() >= 10) begin
      for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
      step(w);
    end
  endtask

  // Place one comma starting at bit offset k of a word, then emit everything
  // needed for it to be seen and output.
  task automatic put_comma(input int k, input logic [9:0] c);
    push_filler(20);
    while (bq.size() % 10 != k) push_filler(1);
    push_bits(c);
    push_filler(10);
    flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    Rst_n   = 1'b0;
    Data_in = '0;
    do_reset();
    check("reset_valid", 32'(RxValid), 32'd0);
    check("reset_data", 32'(Data_out), 32'd0);

    // Aligned stream, comma every 4th word.
    for (int i = 0; i < 3; i++) put_comma(0, RDN);
    check("s1_offset", 32'(Align_offset), 32'd0);
    check("s1_locked", 32'(RxValid), 32'd1);
    check("s1_pulses", 32'(pulse_cnt), 32'd3);

    // Same stream delayed by 3 bits.
    do_reset();
    for (int i = 0; i < 3; i++) put_comma(3, RDN);
    check("s2_offset", 32'(Align_offset), 32'd3);
    check("s2_locked", 32'(RxValid), 32'd1);
    check("s2_comma_word", 32'(last_pulse_data), 32'(RDN));

    // Two commas at 2, then commas at 5.
    do_reset();
    put_comma(2, RDN);
    put_comma(2, RDN);
    put_comma(5, RDN);
    put_comma(5, RDN);
    check("s3_not_yet", 32'(RxValid), 32'd0);
    put_comma(5, RDN);
    check("s3_offset", 32'(Align_offset), 32'd5);
    check("s3_locked", 32'(RxValid), 32'd1);
    check("s3_never_at2", 32'(saw_lock_at2), 32'd0);

    // Alternating disparity at offset 0.
    do_reset();
    put_comma(0, RDN);
    put_comma(0, RDP);
    check("s4_not_yet", 32'(RxValid), 32'd0);
    put_comma(0, RDN);
    check("s4_locked", 32'(RxValid), 32'd1);

    // Foreign commas while locked.
    do_reset();
    for (int i = 0; i < 3; i++) put_comma(0, RDN);
    for (int i = 0; i < 3; i++) put_comma(4, RDN);
    put_comma(0, RDP);
    for (int i = 0; i < 3; i++) put_comma(4, RDN);
    check("s5_hold_valid", 32'(RxValid), 32'd1);
    check("s5_hold_offset", 32'(Align_offset), 32'd0);
    put_comma(4, RDN);
    check("s5_lost", 32'(RxValid), 32'd0);
    check("s5_offset_kept", 32'(Align_offset), 32'd0);

    // Reset while locked, then relock from scratch.
    do_reset();
    for (int i = 0; i < 3; i++) put_comma(6, RDP);
    check("s6_locked", 32'(RxValid), 32'd1);
    do_reset();
    check("s6_rst_valid", 32'(RxValid), 32'd0);
    check("s6_rst_pulse", 32'(Comma_pulse), 32'd0);
    check("s6_rst_offset", 32'(Align_offset), 32'd0);
    put_comma(6, RDP);
    put_comma(6, RDP);
    check("s6_relock_wait", 32'(RxValid), 32'd0);
    put_comma(6, RDP);
    check("s6_relocked", 32'(RxValid), 32'd1);

    // Randomized stream: mostly repeated offsets, occasional moves and noise.
    do_reset();
    k = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) push_bits(10'($urandom));
      put_comma(k, ($urandom_range(0, 1) == 1) ? RDP : RDN);
    end
    for (int i = 0; i < 40; i++) step(10'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
